controller_wr: RTL and testbench

Write-side pointer/flag controller of the asynchronous FIFO, running entirely in the write clock domain. It owns the write pointer and generates the memory write enable. It publishes a registered Gray-coded write pointer for the read domain, and double-flop synchronises the read domain's Gray pointer. From these it derives full, almost_full, a fill-level estimate, and a sticky overflow error.

---
 rtl/controller_wr.sv | 74 +++++++
 tb/tb_controller_wr.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_wr.sv
// rtl/controller_wr.sv - async FIFO write-side pointer/flag controller (wclk domain)
// Owns the write pointer, publishes its Gray copy, synchronises the read pointer and derives flags.
module controller_wr #(
   parameter int PTRWIDTH  = 4,
   parameter int AF_THRESH = 12
) (
   input  logic                wclk,
   input  logic                reset_L,
   input  logic                push,
   input  logic                clr_ovf,
   input  logic [PTRWIDTH:0]   rdptr_gray,
   output logic                wr_en,
   output logic [PTRWIDTH:0]   wrptr_bin,
   output logic [PTRWIDTH:0]   wrptr_gray,
   output logic                full,
   output logic                almost_full,
   output logic [PTRWIDTH:0]   fill_level,
   output logic                overflow
);

   localparam logic [PTRWIDTH:0] PTR_ONE   = (PTRWIDTH+1)'(1);
   localparam logic [PTRWIDTH:0] AF_LEVEL  = (PTRWIDTH+1)'(AF_THRESH);

   logic [PTRWIDTH:0] rd_s1;
   logic [PTRWIDTH:0] rd_s2;
   logic [PTRWIDTH:0] rdptr_sync_bin;
   logic [PTRWIDTH:0] next_bin;
   logic              ovf_set;

   function automatic logic [PTRWIDTH:0] gray2bin(input logic [PTRWIDTH:0] g);
      logic [PTRWIDTH:0] b;
      b[PTRWIDTH] = g[PTRWIDTH];
      for (int i = PTRWIDTH - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign rdptr_sync_bin = gray2bin(rd_s2);
   assign next_bin       = wrptr_bin + PTR_ONE;

   // Full when the pointers match in address but differ in the wrap bit; held low in reset.
   assign full = reset_L
              && (wrptr_bin[PTRWIDTH] != rdptr_sync_bin[PTRWIDTH])
              && (wrptr_bin[PTRWIDTH-1:0] == rdptr_sync_bin[PTRWIDTH-1:0]);

   assign wr_en       = reset_L && push && !full;
   assign fill_level  = wrptr_bin - rdptr_sync_bin;
   assign almost_full = (fill_level >= AF_LEVEL);
   assign ovf_set     = push && full;

   always_ff @(posedge wclk or negedge reset_L) begin
      if (!reset_L) begin
         rd_s1      <= '0;
         rd_s2      <= '0;
         wrptr_bin  <= '0;
         wrptr_gray <= '0;
         overflow   <= 1'b0;
      end else begin
         rd_s1 <= rdptr_gray;
         rd_s2 <= rd_s1;
         if (wr_en) begin
            wrptr_bin  <= next_bin;
            wrptr_gray <= next_bin ^ (next_bin >> 1);
         end
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_controller_wr.sv
// tb/tb_controller_wr.sv - scoreboard bench for controller_wr
module tb_controller_wr;

   typedef struct packed {
      logic [4:0] bin;
      logic [4:0] gray;
      logic [4:0] fill;
      logic       full;
      logic       af;
      logic       ovf;
   } exp_t;

   logic       wclk;
   logic       reset_L;
   logic       push;
   logic       clr_ovf;
   logic [4:0] rdptr_gray;
   logic       wr_en;
   logic [4:0] wrptr_bin;
   logic [4:0] wrptr_gray;
   logic       full;
   logic       almost_full;
   logic [4:0] fill_level;
   logic       overflow;

   int errors = 0;
   int checks = 0;

   exp_t sb[$];
   exp_t mon_exp;
   exp_t mon_obs;

   logic [4:0] m_bin;
   logic [4:0] m_s1;
   logic [4:0] m_s2;
   logic       m_ovf;

   controller_wr #(.PTRWIDTH(4), .AF_THRESH(12)) dut (
      .wclk        (wclk),
      .reset_L     (reset_L),
      .push        (push),
      .clr_ovf     (clr_ovf),
      .rdptr_gray  (rdptr_gray),
      .wr_en       (wr_en),
      .wrptr_bin   (wrptr_bin),
      .wrptr_gray  (wrptr_gray),
      .full        (full),
      .almost_full (almost_full),
      .fill_level  (fill_level),
      .overflow    (overflow)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   function automatic logic [4:0] g2b(input logic [4:0] g);
      logic [4:0] b;
      b = '0;
      for (int k = 0; k < 5; k++) b = b ^ (g >> k);
      return b;
   endfunction

   task automatic model_reset();
      m_bin = '0;
      m_s1  = '0;
      m_s2  = '0;
      m_ovf = 1'b0;
   endtask

   // Drive one cycle of stimulus, predict the post-edge state, queue it, then step past the edge.
   task automatic cyc(input logic p, input logic c, input logic [4:0] rg);
      exp_t       e;
      logic [4:0] rb;
      logic       f;
      push       = p;
      clr_ovf    = c;
      rdptr_gray = rg;
      rb = g2b(m_s2);
      f  = ((m_bin - rb) == 5'd16);
      if (p && f) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (p && !f) m_bin = m_bin + 5'd1;
      m_s2 = m_s1;
      m_s1 = rg;
      rb = g2b(m_s2);
      e.bin  = m_bin;
      e.gray = m_bin ^ (m_bin >> 1);
      e.fill = m_bin - rb;
      e.full = (e.fill == 5'd16);
      e.af   = (e.fill >= 5'd12);
      e.ovf  = m_ovf;
      sb.push_back(e);
      @(posedge wclk);
      #2;
   endtask

   always @(posedge wclk) begin
      #1;
      if (sb.size() > 0) begin
         mon_exp = sb.pop_front();
         mon_obs = {wrptr_bin, wrptr_gray, fill_level, full, almost_full, overflow};
         checks++;
         if (mon_obs !== mon_exp) begin
            errors++;
            $display("FAIL scoreboard t=%0t bin/gray/fill/full/af/ovf got %h/%h/%0d/%b/%b/%b need %h/%h/%0d/%b/%b/%b",
                     $time, mon_obs.bin, mon_obs.gray, mon_obs.fill, mon_obs.full, mon_obs.af, mon_obs.ovf,
                     mon_exp.bin, mon_exp.gray, mon_exp.fill, mon_exp.full, mon_exp.af, mon_exp.ovf);
         end
      end
   end

   task automatic apply_reset();
      reset_L    = 1'b0;
      push       = 1'b0;
      clr_ovf    = 1'b0;
      rdptr_gray = '0;
      model_reset();
      @(posedge wclk);
      #2;
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      reset_L    = 1'b0;
      push       = 1'b1;
      clr_ovf    = 1'b0;
      rdptr_gray = 5'b11000;
      model_reset();
      repeat (3) @(posedge wclk);
      #2;
      checks++;
      if ({wrptr_bin, wrptr_gray, full, wr_en, overflow} !== 13'd0) begin
         errors++;
         $display("FAIL reset_state bin=%h gray=%h full=%b wr_en=%b ovf=%b need all zero",
                  wrptr_bin, wrptr_gray, full, wr_en, overflow);
      end
      reset_L    = 1'b1;
      push       = 1'b0;
      rdptr_gray = '0;
      cyc(1'b1, 1'b0, 5'd0);
      checks++;
      if (wrptr_bin !== 5'd1 || wrptr_gray !== 5'b00001) begin
         errors++;
         $display("FAIL first_push bin=%h gray=%h need 01/01", wrptr_bin, wrptr_gray);
      end
   endtask

   task automatic test_fill();
      apply_reset();
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b1, 1'b0, 5'd0);
         checks++;
         if (almost_full !== (i >= 12)) begin
            errors++;
            $display("FAIL almost_full accept=%0d got %b need %b", i, almost_full, (i >= 12));
         end
      end
      checks++;
      if (full !== 1'b1 || fill_level !== 5'd16 || wrptr_bin !== 5'b10000
          || wrptr_gray !== 5'b11000 || wr_en !== 1'b0) begin
         errors++;
         $display("FAIL at_full full=%b fill=%0d bin=%b gray=%b wr_en=%b need 1/16/10000/11000/0",
                  full, fill_level, wrptr_bin, wrptr_gray, wr_en);
      end
      push = 1'b0;
   endtask

   task automatic test_overflow();
      cyc(1'b1, 1'b0, 5'd0);
      checks++;
      if (overflow !== 1'b1 || wrptr_bin !== 5'b10000) begin
         errors++;
         $display("FAIL ovf_set ovf=%b bin=%b need 1/10000", overflow, wrptr_bin);
      end
      cyc(1'b0, 1'b0, 5'd0);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky got %b need 1", overflow);
      end
      cyc(1'b0, 1'b1, 5'd0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got %b need 0", overflow);
      end
      cyc(1'b1, 1'b1, 5'd0);
      checks++;
      if (overflow !== 1'b1 || wrptr_bin !== 5'b10000) begin
         errors++;
         $display("FAIL ovf_set_priority ovf=%b bin=%b need 1/10000", overflow, wrptr_bin);
      end
      cyc(1'b0, 1'b1, 5'd0);
   endtask

   task automatic test_drain();
      cyc(1'b0, 1'b0, 5'b00110);
      checks++;
      if (full !== 1'b1) begin
         errors++;
         $display("FAIL drain_edge1 full got %b need 1", full);
      end
      cyc(1'b0, 1'b0, 5'b00110);
      checks++;
      if (full !== 1'b0 || fill_level !== 5'd12 || almost_full !== 1'b1) begin
         errors++;
         $display("FAIL drain_edge2 full=%b fill=%0d af=%b need 0/12/1", full, fill_level, almost_full);
      end
   endtask

   task automatic test_wrap();
      logic [4:0] dl[$];
      logic [4:0] prev_gray;
      logic [4:0] prev_bin;
      logic [4:0] rg;
      int         wraps;
      int         bad_step;
      int         saw_full;
      apply_reset();
      dl = '{5'd0, 5'd0, 5'd0, 5'd0};
      wraps = 0;
      bad_step = 0;
      saw_full = 0;
      for (int i = 0; i < 40; i++) begin
         prev_gray = wrptr_gray;
         prev_bin  = wrptr_bin;
         rg = dl.pop_front();
         cyc(1'b1, 1'b0, rg);
         dl.push_back(wrptr_gray);
         if ($countones(prev_gray ^ wrptr_gray) != 1) bad_step++;
         if (full) saw_full++;
         if (prev_bin == 5'd31 && wrptr_bin == 5'd0) wraps++;
      end
      push = 1'b0;
      checks++;
      if (bad_step != 0 || saw_full != 0) begin
         errors++;
         $display("FAIL wrap_gray_full bad_steps=%0d full_cycles=%0d need 0/0", bad_step, saw_full);
      end
      checks++;
      if (wraps != 1 || wrptr_bin !== 5'd8) begin
         errors++;
         $display("FAIL wrap_count wraps=%0d bin=%0d need 1/8", wraps, wrptr_bin);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (3) cyc(1'b1, 1'b0, 5'd0);
      cyc(1'b1, 1'b0, 5'd0);
      #3;
      reset_L = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({wrptr_bin, wrptr_gray, fill_level, full, almost_full, wr_en, overflow} !== 19'd0) begin
         errors++;
         $display("FAIL async_reset bin=%h gray=%h fill=%0d full=%b af=%b wr_en=%b ovf=%b need all zero",
                  wrptr_bin, wrptr_gray, fill_level, full, almost_full, wr_en, overflow);
      end
      push = 1'b0;
      @(posedge wclk);
      #2;
      reset_L = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_wrap();
      test_async_reset();
      repeat (2) @(posedge wclk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain leftover=%0d need 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
